// File: rtl/guess_turn_sequencer.sv
// Turn scheduler and scoring datapath for the two-player guess game.
// Optional per-turn idle timeout is built when TURN_TIMEOUT_EN is defined.
module guess_turn_sequencer #(
  parameter int GUESS_W        = 4,
  parameter int LIVES          = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [GUESS_W-1:0] secret,
  input  logic               p1_submit,
  input  logic               p2_submit,
  input  logic [GUESS_W-1:0] p1_guess,
  input  logic [GUESS_W-1:0] p2_guess,
  output logic [1:0]         turn,
  output logic               bingo1,
  output logic               bingo2,
  output logic [1:0]         lifeOut1,
  output logic [1:0]         lifeOut2,
  output logic [1:0]         hint,
  output logic               result_valid,
  output logic               game_over,
  output logic [1:0]         who
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P1   = 3'd1;
  localparam logic [2:0] S_P2   = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  localparam logic [1:0] H_NONE = 2'b00;
  localparam logic [1:0] H_LOW  = 2'b01;
  localparam logic [1:0] H_HIGH = 2'b10;
  localparam logic [1:0] H_TO   = 2'b11;

  generate
    if (LIVES < 1 || LIVES > 3 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("guess_turn_sequencer: illegal LIVES or TIMEOUT_CYCLES");
    end
  endgenerate

  logic [2:0]         state_q, state_d;
  logic [GUESS_W-1:0] secret_q, secret_d;
  logic [GUESS_W-1:0] guess_q, guess_d;
  logic               owner_q, owner_d;
  logic               to_q, to_d;
  logic               bingo1_q, bingo1_d;
  logic               bingo2_q, bingo2_d;
  logic [1:0]         life1_q, life1_d;
  logic [1:0]         life2_q, life2_d;
  logic [1:0]         hint_q, hint_d;
  logic               rv_q, rv_d;
  logic [1:0]         who_q, who_d;
  logic               expired;

  // owner_q: 0 = player 1, 1 = player 2
  logic [1:0] own_life;
  logic [1:0] oth_life;
  logic [1:0] own_dec;
  logic       hit;
  logic       low;

  always_comb begin
    own_life = owner_q ? life2_q : life1_q;
    oth_life = owner_q ? life1_q : life2_q;
    own_dec  = (own_life == 2'd0) ? 2'd0 : own_life - 2'd1;
    hit      = !to_q && (guess_q == secret_q);
    low      = guess_q < secret_q;
  end

`ifdef TURN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_wait;

  assign in_wait = (state_q == S_P1) || (state_q == S_P2);
  assign expired = in_wait && (cnt_q == CNT_LAST);

  // Counting restarts whenever a wait state is (re)entered.
  always_comb begin
    cnt_d = '0;
    if (in_wait && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    owner_d  = owner_q;
    to_d     = to_q;
    bingo1_d = bingo1_q;
    bingo2_d = bingo2_q;
    life1_d  = life1_q;
    life2_d  = life2_q;
    hint_d   = hint_q;
    who_d    = who_q;
    rv_d     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          secret_d = secret;
          life1_d  = LIVES_INIT;
          life2_d  = LIVES_INIT;
          bingo1_d = 1'b0;
          bingo2_d = 1'b0;
          hint_d   = H_NONE;
          who_d    = 2'b00;
          to_d     = 1'b0;
          state_d  = S_P1;
        end
      end

      S_P1: begin
        if (p1_submit) begin
          guess_d = p1_guess;
          owner_d = 1'b0;
          to_d    = 1'b0;
          state_d = S_EVAL;
        end else if (expired) begin
          owner_d = 1'b0;
          to_d    = 1'b1;
          state_d = S_EVAL;
        end
      end

      S_P2: begin
        if (p2_submit) begin
          guess_d = p2_guess;
          owner_d = 1'b1;
          to_d    = 1'b0;
          state_d = S_EVAL;
        end else if (expired) begin
          owner_d = 1'b1;
          to_d    = 1'b1;
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        rv_d = 1'b1;
        unique case (1'b1)
          hit: begin
            hint_d  = H_NONE;
            state_d = S_DONE;
            if (owner_q) begin
              bingo2_d = 1'b1;
              who_d    = 2'b10;
            end else begin
              bingo1_d = 1'b1;
              who_d    = 2'b01;
            end
          end
          default: begin
            hint_d = to_q ? H_TO : (low ? H_LOW : H_HIGH);
            if (owner_q) begin
              life2_d = own_dec;
            end else begin
              life1_d = own_dec;
            end
            if ((own_dec == 2'd0) && (oth_life == 2'd0)) begin
              who_d   = 2'b00;
              state_d = S_DONE;
            end else if (oth_life != 2'd0) begin
              state_d = owner_q ? S_P1 : S_P2;
            end else begin
              state_d = owner_q ? S_P2 : S_P1;
            end
          end
        endcase
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      secret_q <= '0;
      guess_q  <= '0;
      owner_q  <= 1'b0;
      to_q     <= 1'b0;
      bingo1_q <= 1'b0;
      bingo2_q <= 1'b0;
      life1_q  <= 2'd0;
      life2_q  <= 2'd0;
      hint_q   <= H_NONE;
      rv_q     <= 1'b0;
      who_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      owner_q  <= owner_d;
      to_q     <= to_d;
      bingo1_q <= bingo1_d;
      bingo2_q <= bingo2_d;
      life1_q  <= life1_d;
      life2_q  <= life2_d;
      hint_q   <= hint_d;
      rv_q     <= rv_d;
      who_q    <= who_d;
    end
  end

  always_comb begin
    unique case (state_q)
      S_P1:    turn = 2'b01;
      S_P2:    turn = 2'b10;
      S_EVAL:  turn = owner_q ? 2'b10 : 2'b01;
      S_DONE:  turn = 2'b11;
      default: turn = 2'b00;
    endcase
  end

  assign bingo1       = bingo1_q;
  assign bingo2       = bingo2_q;
  assign lifeOut1     = life1_q;
  assign lifeOut2     = life2_q;
  assign hint         = hint_q;
  assign result_valid = rv_q;
  assign game_over    = (state_q == S_DONE);
  assign who          = who_q;

endmodule

// File: tb/tb_guess_turn_sequencer.sv
// Directed bench for guess_turn_sequencer.
// Timeout steps run only when TURN_TIMEOUT_EN is defined.
module tb_guess_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] secret;
  logic       p1_submit;
  logic       p2_submit;
  logic [3:0] p1_guess;
  logic [3:0] p2_guess;
  logic [1:0] turn;
  logic       bingo1;
  logic       bingo2;
  logic [1:0] lifeOut1;
  logic [1:0] lifeOut2;
  logic [1:0] hint;
  logic       result_valid;
  logic       game_over;
  logic [1:0] who;

  int passed = 0;
  int total  = 0;

  guess_turn_sequencer #(
    .GUESS_W(4),
    .LIVES(3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .secret(secret),
    .p1_submit(p1_submit),
    .p2_submit(p2_submit),
    .p1_guess(p1_guess),
    .p2_guess(p2_guess),
    .turn(turn),
    .bingo1(bingo1),
    .bingo2(bingo2),
    .lifeOut1(lifeOut1),
    .lifeOut2(lifeOut2),
    .hint,
    .result_valid(result_valid),
    .game_over(game_over),
    .who(who)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pulse one submit, then step through EVAL to the result cycle.
  task automatic play(input int p, input logic [3:0] g);
    if (p == 1) begin
      p1_submit = 1'b1;
      p1_guess  = g;
    end else begin
      p2_submit = 1'b1;
      p2_guess  = g;
    end
    tick();
    p1_submit = 1'b0;
    p2_submit = 1'b0;
    tick();
  endtask

  task automatic begin_game(input logic [3:0] s);
    start  = 1'b1;
    secret = s;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    secret    = 4'd0;
    p1_submit = 1'b0;
    p2_submit = 1'b0;
    p1_guess  = 4'd0;
    p2_guess  = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();

    chk("rst_turn", turn, 2'b00);
    chk("rst_bingo1", bingo1, 1'b0);
    chk("rst_bingo2", bingo2, 1'b0);
    chk("rst_life1", lifeOut1, 2'd0);
    chk("rst_life2", lifeOut2, 2'd0);
    chk("rst_hint", hint, 2'b00);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_over", game_over, 1'b0);
    chk("rst_who", who, 2'b00);

    play(1, 4'd5);
    chk("idle_sub_rv", result_valid, 1'b0);
    chk("idle_sub_turn", turn, 2'b00);

    begin_game(4'd7);
    chk("start_turn", turn, 2'b01);
    chk("start_life1", lifeOut1, 2'd3);
    chk("start_life2", lifeOut2, 2'd3);
    p1_submit = 1'b1;
    p1_guess  = 4'd7;
    tick();
    p1_submit = 1'b0;
    chk("eval_turn", turn, 2'b01);
    chk("eval_rv", result_valid, 1'b0);
    tick();
    chk("hit_bingo1", bingo1, 1'b1);
    chk("hit_rv", result_valid, 1'b1);
    chk("hit_turn", turn, 2'b11);
    chk("hit_over", game_over, 1'b1);
    chk("hit_who", who, 2'b01);
    chk("hit_life1", lifeOut1, 2'd3);
    chk("hit_hint", hint, 2'b00);
    tick();
    chk("hit_rv_once", result_valid, 1'b0);
    chk("done_hold", game_over, 1'b1);

    begin_game(4'd7);
    chk("restart_bingo1", bingo1, 1'b0);
    chk("restart_over", game_over, 1'b0);
    play(1, 4'd3);
    chk("low_hint", hint, 2'b01);
    chk("low_life1", lifeOut1, 2'd2);
    chk("low_turn", turn, 2'b10);
    play(2, 4'd9);
    chk("high_hint", hint, 2'b10);
    chk("high_life2", lifeOut2, 2'd2);
    chk("high_turn", turn, 2'b01);
    play(1, 4'd7);
    chk("win_who", who, 2'b01);
    chk("win_bingo2", bingo2, 1'b0);
    chk("win_bingo1", bingo1, 1'b1);

    begin_game(4'd7);
    play(1, 4'd0);
    chk("m1_life1", lifeOut1, 2'd2);
    play(2, 4'd15);
    chk("m2_life2", lifeOut2, 2'd2);
    play(1, 4'd0);
    chk("m3_life1", lifeOut1, 2'd1);
    play(2, 4'd15);
    chk("m4_life2", lifeOut2, 2'd1);
    play(1, 4'd0);
    chk("m5_life1", lifeOut1, 2'd0);
    chk("m5_turn", turn, 2'b10);
    chk("m5_over", game_over, 1'b0);
    play(2, 4'd15);
    chk("m6_life2", lifeOut2, 2'd0);
    chk("draw_over", game_over, 1'b1);
    chk("draw_who", who, 2'b00);
    chk("draw_turn", turn, 2'b11);

    begin_game(4'd7);
    play(2, 4'd7);
    chk("p2_ign_rv", result_valid, 1'b0);
    chk("p2_ign_turn", turn, 2'b01);
    chk("p2_ign_bingo2", bingo2, 1'b0);
    p1_submit = 1'b1;
    p1_guess  = 4'd2;
    p2_submit = 1'b1;
    p2_guess  = 4'd7;
    tick();
    p1_submit = 1'b0;
    p2_submit = 1'b0;
    tick();
    chk("both_hint", hint, 2'b01);
    chk("both_life1", lifeOut1, 2'd2);
    chk("both_life2", lifeOut2, 2'd3);
    chk("both_bingo2", bingo2, 1'b0);
    chk("both_turn", turn, 2'b10);

    p2_submit = 1'b1;
    p2_guess  = 4'd9;
    tick();
    p2_guess  = 4'd7;
    tick();
    p2_submit = 1'b0;
    chk("evsub_hint", hint, 2'b10);
    chk("evsub_life2", lifeOut2, 2'd2);
    chk("evsub_turn", turn, 2'b01);
    tick();
    chk("evsub_rv", result_valid, 1'b0);
    chk("evsub_bingo2", bingo2, 1'b0);

    p1_submit = 1'b1;
    p1_guess  = 4'd4;
    tick();
    p1_submit = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    chk("rst_eval_turn", turn, 2'b00);
    chk("rst_eval_rv", result_valid, 1'b0);
    chk("rst_eval_life1", lifeOut1, 2'd0);
    tick();
    chk("rst_eval_rv2", result_valid, 1'b0);
    chk("rst_eval_hint", hint, 2'b00);

`ifdef TURN_TIMEOUT_EN
    begin_game(4'd7);
    repeat (8) tick();
    chk("to_eval_turn", turn, 2'b01);
    tick();
    chk("to_hint", hint, 2'b11);
    chk("to_life1", lifeOut1, 2'd2);
    chk("to_turn", turn, 2'b10);
    chk("to_rv", result_valid, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
